uart_tx_scheduler: RTL

- Shares the single UART transmitter between the left and right lane note-event sources of the game.
- Each source pushes ASCII bytes into its own small FIFO.
- A round-robin scheduler drains the FIFOs one byte at a time into the UART's tx_start/tx_data/tx_ready handshake.
- Optionally each byte is prefixed with a channel tag byte so the Python host can demultiplex the stream.

---
 rtl/uart_tx_scheduler_pkg.sv | 18 +
 rtl/sched_byte_fifo.sv | 46 ++++
 rtl/uart_tx_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the two-lane UART transmit scheduler.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendTag,
    StWaitTag,
    StSendData,
    StWaitData
  } sched_state_e;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  localparam logic [7:0] TAG_L_DEFAULT = 8'h4C;
  localparam logic [7:0] TAG_R_DEFAULT = 8'h52;

endpackage

// File: rtl/sched_byte_fifo.sv
// Small byte FIFO with combinational head read; a push is refused whenever full.
module sched_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Fullness is judged before any same-cycle pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding left/right lane bytes, optionally tagged, into one UART.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          TAG_EN     = 1'b1,
  parameter logic [7:0]  TAG_L      = TAG_L_DEFAULT,
  parameter logic [7:0]  TAG_R      = TAG_R_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l_valid,
  input  logic [7:0] l_data,
  output logic       l_ready,
  input  logic       r_valid,
  input  logic [7:0] r_data,
  output logic       r_ready,
  output logic       uart_tx_start,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_ready,
  output logic       busy
);

  sched_state_e state_q;
  logic         grant_q, last_grant_q, sel;
  logic         l_full, l_empty, r_full, r_empty, l_pop, r_pop;
  logic [7:0]   l_head, r_head, sel_head, grant_head;

  sched_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_l (
    .clk   (clk),
    .rst   (rst),
    .push  (l_valid),
    .din   (l_data),
    .pop   (l_pop),
    .dout  (l_head),
    .full  (l_full),
    .empty (l_empty)
  );

  sched_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo_r (
    .clk   (clk),
    .rst   (rst),
    .push  (r_valid),
    .din   (r_data),
    .pop   (r_pop),
    .dout  (r_head),
    .full  (r_full),
    .empty (r_empty)
  );

  assign l_ready = ~l_full;
  assign r_ready = ~r_full;

  // On a tie the channel that did not win last time gets the UART.
  always_comb begin
    sel = CH_L;
    if (!l_empty && !r_empty) sel = ~last_grant_q;
    else if (l_empty)         sel = CH_R;
  end

  assign sel_head   = (sel == CH_R) ? r_head : l_head;
  assign grant_head = (grant_q == CH_R) ? r_head : l_head;

  assign uart_tx_start = (state_q == StSendTag) || (state_q == StSendData);
  assign busy          = (state_q != StIdle);
  assign l_pop         = (state_q == StSendData) && (grant_q == CH_L);
  assign r_pop         = (state_q == StSendData) && (grant_q == CH_R);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_q      <= CH_L;
      last_grant_q <= CH_R;
      uart_tx_data <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (uart_tx_ready && (!l_empty || !r_empty)) begin
            grant_q      <= sel;
            last_grant_q <= sel;
            if (TAG_EN) begin
              uart_tx_data <= (sel == CH_R) ? TAG_R : TAG_L;
              state_q      <= StSendTag;
            end else begin
              uart_tx_data <= sel_head;
              state_q      <= StSendData;
            end
          end
        end
        StSendTag:  state_q <= StWaitTag;
        StWaitTag: begin
          if (uart_tx_ready) begin
            uart_tx_data <= grant_head;
            state_q      <= StSendData;
          end
        end
        StSendData: state_q <= StWaitData;
        StWaitData: if (uart_tx_ready) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule
